// File: rtl/encoder_4_to_2_seq_pkg.sv
// encoder_4_to_2_seq_pkg: shared constants, FSM state codes and one-hot helper for the buffered encoder.
package encoder_4_to_2_seq_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = $clog2(N_DEF);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;
  function automatic logic [31:0] onehot(input int i);
    return 32'd1 << i;
  endfunction
endpackage

// File: rtl/encoder_4_to_2_seq_if.sv
// encoder_4_to_2_seq_if: request lines, output code handshake and status of the buffered encoder.
interface encoder_4_to_2_seq_if #(parameter int N = 4);
  localparam int W = $clog2(N);
  logic         EN;
  logic [N-1:0] D;
  logic         RDY;
  logic [W-1:0] A;
  logic         V;
  logic [N-1:0] PEND;
  logic         DUP;
  modport master (output EN, D, RDY, input A, V, PEND, DUP);
  modport slave  (input EN, D, RDY, output A, V, PEND, DUP);
endinterface

// File: rtl/encoder_4_to_2_seq_prio_pick.sv
// prio_pick: combinational pick of one set bit; highest index wins, or first upward from start when RR=1.
module prio_pick #(
  parameter int N  = 4,
  parameter bit RR = 1'b0,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  // Later hits overwrite earlier ones, so scan order sets the priority.
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = RR ? start + W'(N - 1 - k) : W'(k);
      if (vec[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/encoder_4_to_2_seq.sv
// encoder_4_to_2_seq: sticky request capture plus one-deep output stage emitting one code per clk.
// Define ROUND_ROBIN_EN for rotating priority; otherwise fixed highest-index-wins.
module encoder_4_to_2_seq
  import encoder_4_to_2_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input logic clk,
  input logic rst,
  encoder_4_to_2_seq_if.slave bus
);
  localparam int W = $clog2(N);
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic [0:0]   state_q, state_d;
  logic [N-1:0] pend_q, pend_d, cap, clr;
  logic [W-1:0] a_q, a_d, idx, start;
  logic         found, load, dup_q, dup_d;
`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
  assign ptr_d = load ? idx + 1'b1 : ptr_q;
  always_ff @(posedge clk)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
`else
  assign start = '0;
`endif
  prio_pick #(.N(N), .RR(RR)) u_pick (
    .vec(pend_q),
    .start(start),
    .found(found),
    .idx(idx)
  );
  // A bit cleared by a grant and recaptured in the same cycle is a fresh event, not a duplicate.
  always_comb begin
    cap = bus.EN ? bus.D : '0;
    load = found && (state_q == S_EMPTY || bus.RDY);
    clr = load ? N'(onehot(int'(idx))) : '0;
    pend_d = (pend_q & ~clr) | cap;
    dup_d = |(cap & pend_q & ~clr);
    a_d = load ? idx : a_q;
    state_d = load ? S_FULL : (bus.RDY ? S_EMPTY : state_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      pend_q <= '0;
      a_q <= '0;
      dup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      a_q <= a_d;
      dup_q <= dup_d;
    end
  end
  assign bus.A = a_q;
  assign bus.V = state_q == S_FULL;
  assign bus.PEND = pend_q;
  assign bus.DUP = dup_q;
endmodule

// File: tb/tb_encoder_4_to_2_seq.sv
// tb_encoder_4_to_2_seq: directed vectors with hand-computed expectations for the buffered encoder.
module tb_encoder_4_to_2_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  encoder_4_to_2_seq_if #(.N(4)) bus ();
  encoder_4_to_2_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic out(input string tag, input logic v, input logic [1:0] a, input logic [3:0] p);
    chk({tag, ".V"}, 32'(bus.V), 32'(v));
    chk({tag, ".A"}, 32'(bus.A), 32'(a));
    chk({tag, ".PEND"}, 32'(bus.PEND), 32'(p));
  endtask
  initial begin
    bus.EN = 1'b1; bus.D = 4'b1111; bus.RDY = 1'b1;
    rst = 1'b1;
    tick();
    out("reset", 1'b0, 2'd0, 4'b0000);
    chk("reset.DUP", 32'(bus.DUP), 32'd0);
    rst = 1'b0; bus.D = 4'b0000;
    tick();
    out("idle", 1'b0, 2'd0, 4'b0000);
    bus.D = 4'b0100;
    tick();
    out("single.t1", 1'b0, 2'd0, 4'b0100);
    bus.D = 4'b0000;
    tick();
    out("single.t2", 1'b1, 2'd2, 4'b0000);
    tick();
    out("single.t3", 1'b0, 2'd2, 4'b0000);
`ifndef ROUND_ROBIN_EN
    bus.D = 4'b1011;
    tick();
    out("prio.t1", 1'b0, 2'd2, 4'b1011);
    bus.D = 4'b0000;
    tick();
    out("prio.a3", 1'b1, 2'd3, 4'b0011);
    tick();
    out("prio.a1", 1'b1, 2'd1, 4'b0001);
    tick();
    out("prio.a0", 1'b1, 2'd0, 4'b0000);
    tick();
    out("prio.end", 1'b0, 2'd0, 4'b0000);
`endif
    bus.RDY = 1'b0; bus.D = 4'b0001;
    tick();
    chk("bp.pend", 32'(bus.PEND), 32'b0001);
    bus.D = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      out("bp.hold", 1'b1, 2'd0, 4'b0000);
    end
    bus.RDY = 1'b1;
    tick();
    out("bp.release", 1'b0, 2'd0, 4'b0000);
    bus.EN = 1'b0; bus.D = 4'b1111;
    tick();
    chk("en.mask", 32'(bus.PEND), 32'd0);
    chk("en.dup", 32'(bus.DUP), 32'd0);
    bus.EN = 1'b1; bus.RDY = 1'b0; bus.D = 4'b1000;
    tick();
    bus.D = 4'b0000;
    tick();
    out("dup.fill", 1'b1, 2'd3, 4'b0000);
    bus.D = 4'b0010;
    tick();
    chk("dup.first", 32'(bus.DUP), 32'd0);
    chk("dup.pend1", 32'(bus.PEND), 32'b0010);
    tick();
    chk("dup.merge", 32'(bus.DUP), 32'd1);
    chk("dup.pend2", 32'(bus.PEND), 32'b0010);
    bus.D = 4'b0000;
    tick();
    chk("dup.pulse", 32'(bus.DUP), 32'd0);
    bus.RDY = 1'b1; bus.D = 4'b0010;
    tick();
    out("dup.recap", 1'b1, 2'd1, 4'b0010);
    chk("dup.recap.DUP", 32'(bus.DUP), 32'd0);
    bus.D = 4'b0000;
    tick();
    out("dup.again", 1'b1, 2'd1, 4'b0000);
    tick();
    out("dup.end", 1'b0, 2'd1, 4'b0000);
`ifdef ROUND_ROBIN_EN
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.D = 4'b1111; bus.RDY = 1'b1;
    tick();
    chk("rr.pend", 32'(bus.PEND), 32'b1111);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("rr.V", 32'(bus.V), 32'd1);
      chk("rr.A", 32'(bus.A), 32'(k % 4));
    end
    bus.D = 4'b0000;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
